ama_riscv_imem_resp: RTL

AMA_RISCV_IMEM_RESP -- requirements
Module: ama_riscv_imem_resp

---
 rtl/ama_riscv_imem_resp.sv | 102 ++++++++++
 1 files changed

// File: rtl/ama_riscv_imem_resp.sv
// Read-only instruction memory responder: fixed-latency read pipeline feeding an
// in-order response FIFO, with outstanding-request accounting and flush support.
module ama_riscv_imem_resp #(
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    // Preloaded through a hierarchical backdoor; there is no write port.
    logic [31:0]   mem [MEM_WORDS];

    logic          pv_q [LATENCY];
    logic [31:0]   pd_q [LATENCY];
    logic [31:0]   fq_q [QDEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] fcnt_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q;

    logic          accept, xfer, pop, push, fifo_empty;
    logic [AW-1:0] widx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        widx       = req_addr[AW+1:2];
        accept     = req_valid && rdy_q;
        fifo_empty = (fcnt_q == '0);
        // The pipeline tail is shown directly when the FIFO is empty, so an
        // idle responder answers exactly LATENCY cycles after acceptance.
        rsp_valid  = !fifo_empty || pv_q[LATENCY-1];
        rsp_data   = !fifo_empty ? fq_q[rd_q] : (pv_q[LATENCY-1] ? pd_q[LATENCY-1] : '0);
        xfer       = rsp_valid && rsp_ready;
        pop        = !fifo_empty && rsp_ready;
        push       = pv_q[LATENCY-1] && !(fifo_empty && rsp_ready);
        req_ready  = rdy_q;
        if (flush) begin
            cnt_d = CW'(accept);
        end else begin
            cnt_d = cnt_q + CW'(accept) - CW'(xfer);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
            end
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                fq_q[i] <= '0;
            end
            rd_q   <= '0;
            wr_q   <= '0;
            fcnt_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            pv_q[0] <= accept;
            if (accept) begin
                pd_q[0] <= mem[widx];
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1] && !flush;
                pd_q[i] <= pd_q[i-1];
            end
            if (flush) begin
                rd_q   <= '0;
                wr_q   <= '0;
                fcnt_q <= '0;
            end else begin
                if (push) begin
                    fq_q[wr_q] <= pd_q[LATENCY-1];
                    wr_q       <= ptr_inc(wr_q);
                end
                if (pop) begin
                    rd_q <= ptr_inc(rd_q);
                end
                fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
            end
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d < CW'(QDEPTH));
        end
    end

endmodule
